// File: rtl/mrc_pkg.sv
// rtl/mrc_pkg.sv - shared helpers for the multi-rate counter: rate periods and prescaler width
package mrc_pkg;

  function automatic int unsigned rate_period(input int unsigned clk_hz, input int unsigned base_hz,
                                              input int unsigned shift, input int unsigned k);
    return clk_hz / (base_hz << (shift * k));
  endfunction

  // Wide enough to hold the slowest period minus one; never zero bits.
  function automatic int unsigned psc_width(input int unsigned clk_hz, input int unsigned base_hz);
    return ((clk_hz / base_hz) <= 2) ? 1 : $clog2(clk_hz / base_hz);
  endfunction

endpackage

// File: rtl/rate_prescaler.sv
// rtl/rate_prescaler.sv - free-running prescaler that raises tick_en once per selected period
module rate_prescaler
  import mrc_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned BASE_HZ   = 1,
  parameter int unsigned NUM_RATES = 4,
  parameter int unsigned SHIFT     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_RATES)-1:0] sel_q,
  input  logic                         en,
  input  logic                         clr,
  output logic                         tick_en
);

  localparam int unsigned PSC_W = psc_width(CLK_HZ, BASE_HZ);

  logic [PSC_W-1:0] psc;
  logic [PSC_W-1:0] last;

  always_comb begin
    last = PSC_W'(rate_period(CLK_HZ, BASE_HZ, SHIFT, 32'(sel_q)) - 32'd1);
  end

  // A clear always wins so the first tick after it lands a full period later.
  assign tick_en = en && !clr && (psc == last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (clr) begin
      psc <= '0;
    end else if (en) begin
      psc <= tick_en ? '0 : psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/multi_rate_counter.sv
// rtl/multi_rate_counter.sv - selectable-rate up/down counter with load, wrap/saturate and tick/terminal pulses
module multi_rate_counter
  import mrc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned BASE_HZ   = 1,
  parameter int unsigned NUM_RATES = 4,
  parameter int unsigned SHIFT     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [$clog2(NUM_RATES)-1:0] sel,
  input  logic                         dir,
  input  logic                         sat,
  input  logic                         load,
  input  logic [WIDTH-1:0]             load_val,
  output logic [WIDTH-1:0]             count,
  output logic                         tick,
  output logic                         terminal
);

  localparam int unsigned SEL_W = $clog2(NUM_RATES);

  if (NUM_RATES < 2) begin : g_bad_num_rates
    $error("multi_rate_counter: NUM_RATES must be at least 2");
  end
  if ((CLK_HZ % (BASE_HZ << (SHIFT * (NUM_RATES - 1)))) != 0) begin : g_bad_rate
    $error("multi_rate_counter: CLK_HZ is not a multiple of the fastest tick rate");
  end

  logic [SEL_W-1:0] sel_c;
  logic [SEL_W-1:0] sel_q;
  logic             sel_change;
  logic             clr;
  logic             tick_en;
  logic             at_limit;
  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    sel_c = (32'(sel) >= NUM_RATES) ? SEL_W'(NUM_RATES - 1) : sel;
  end

  // A rate change is only taken while enabled; otherwise it waits for en.
  assign sel_change = en && !load && (sel_c != sel_q);
  assign clr        = load || sel_change;

  always_comb begin
    at_limit  = dir ? (count == '1) : (count == '0);
    count_nxt = dir ? count + WIDTH'(1) : count - WIDTH'(1);
    if (at_limit) begin
      count_nxt = sat ? count : (dir ? '0 : '1);
    end
  end

  rate_prescaler #(
    .CLK_HZ   (CLK_HZ),
    .BASE_HZ  (BASE_HZ),
    .NUM_RATES(NUM_RATES),
    .SHIFT    (SHIFT)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .sel_q  (sel_q),
    .en     (en),
    .clr    (clr),
    .tick_en(tick_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      tick     <= 1'b0;
      terminal <= 1'b0;
      sel_q    <= '0;
    end else if (load) begin
      count    <= load_val;
      tick     <= 1'b0;
      terminal <= 1'b0;
    end else if (sel_change) begin
      sel_q    <= sel_c;
      tick     <= 1'b0;
      terminal <= 1'b0;
    end else if (tick_en) begin
      count    <= count_nxt;
      tick     <= 1'b1;
      terminal <= at_limit;
    end else begin
      tick     <= 1'b0;
      terminal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_rate_counter.sv
// tb/tb_multi_rate_counter.sv - directed and randomized checks of multi_rate_counter against a rate/count model
module tb_multi_rate_counter;

  localparam int WIDTH     = 4;
  localparam int CLK_HZ    = 64;
  localparam int BASE_HZ   = 1;
  localparam int NUM_RATES = 4;
  localparam int SHIFT     = 2;
  localparam int MAXC      = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       sel = 2'd0;
  logic             dir = 1'b1;
  logic             sat = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             terminal;

  int checks = 0;
  int errors = 0;

  int m_count = 0;
  int m_elapsed = 0;
  int m_sel = 0;
  int m_tick = 0;
  int m_term = 0;

  multi_rate_counter #(
    .WIDTH    (WIDTH),
    .CLK_HZ   (CLK_HZ),
    .BASE_HZ  (BASE_HZ),
    .NUM_RATES(NUM_RATES),
    .SHIFT    (SHIFT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sel     (sel),
    .dir     (dir),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tick    (tick),
    .terminal(terminal)
  );

  always #5 clk = ~clk;

  function automatic int period(input int k);
    return CLK_HZ / (BASE_HZ * (1 << (SHIFT * k)));
  endfunction

  function automatic int clamp_sel(input int s);
    return (s >= NUM_RATES) ? NUM_RATES - 1 : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int nxt;
    m_tick = 0;
    m_term = 0;
    if (!rst_n) begin
      m_count   = 0;
      m_elapsed = 0;
      m_sel     = 0;
    end else if (load) begin
      m_count   = int'(load_val);
      m_elapsed = 0;
    end else if (!en) begin
      m_tick = 0;
    end else if (clamp_sel(int'(sel)) != m_sel) begin
      m_sel     = clamp_sel(int'(sel));
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      if (m_elapsed == period(m_sel)) begin
        m_elapsed = 0;
        m_tick    = 1;
        nxt       = m_count + (dir ? 1 : -1);
        m_term    = (nxt < 0 || nxt > MAXC) ? 1 : 0;
        if (!(m_term != 0 && sat))
          m_count = (nxt + MAXC + 1) % (MAXC + 1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("count", 32'(count), m_count);
    chk("tick", 32'(tick), m_tick);
    chk("terminal", 32'(terminal), m_term);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [WIDTH-1:0] frozen;

    // 1: reset, then the 1 Hz rate ticks on the 64th edge and wraps after 16 ticks
    rst_n = 1'b0;
    run(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_tick", 32'(tick), 0);
    rst_n = 1'b1;
    en = 1'b1; sel = 2'd0; dir = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      step();
      if (i == 64) begin
        chk("t1_first_tick", 32'(tick), 1);
        chk("t1_first_count", 32'(count), 1);
      end
      if (i == 1024) begin
        chk("t1_wrap_count", 32'(count), 0);
        chk("t1_wrap_terminal", 32'(terminal), 1);
      end
    end

    // 2: switch sel=1 -> sel=2 mid-period; first new tick on 5th edge
    sel = 2'd1;
    run(1 + 16 + 7);
    sel = 2'd2;
    step();
    chk("t2_switch_tick", 32'(tick), 0);
    for (int j = 2; j <= 5; j++) begin
      step();
      chk("t2_new_rate_tick", 32'(tick), (j == 5) ? 1 : 0);
    end

    // 3: saturate at zero counting down at full rate, then wrap
    load = 1'b1; load_val = 4'd0;
    step();
    chk("t3_load0", 32'(count), 0);
    load = 1'b0; sel = 2'd3; dir = 1'b0; sat = 1'b1;
    step();
    chk("t3_switch_tick", 32'(tick), 0);
    repeat (5) begin
      step();
      chk("t3_sat_count", 32'(count), 0);
      chk("t3_sat_terminal", 32'(terminal), 1);
    end
    sat = 1'b0;
    step();
    chk("t3_wrap_15", 32'(count), 15);
    chk("t3_wrap_terminal", 32'(terminal), 1);
    step();
    chk("t3_down_14", 32'(count), 14);
    chk("t3_down_terminal", 32'(terminal), 0);

    // 4: load pulse during full-rate counting
    dir = 1'b1;
    run(2);
    load = 1'b1; load_val = 4'd9;
    step();
    chk("t4_load_count", 32'(count), 9);
    chk("t4_load_tick", 32'(tick), 0);
    load = 1'b0;
    step();
    chk("t4_count10", 32'(count), 10);
    step();
    chk("t4_count11", 32'(count), 11);

    // 5: en low for 20 cycles with psc=5 at sel=1
    sel = 2'd1;
    run(1 + 5);
    frozen = count;
    en = 1'b0;
    run(20);
    chk("t5_frozen", 32'(count), 32'(frozen));
    en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk("t5_resume_tick", 32'(tick), (k == 11) ? 1 : 0);
    end

    // 6: synchronous reset mid-count at 7
    sel = 2'd3;
    step();
    load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0;
    step();
    chk("t6_count7", 32'(count), 7);
    rst_n = 1'b0;
    #2;
    chk("t6_before_edge", 32'(count), 7);
    step();
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_tick", 32'(tick), 0);
    chk("t6_rst_terminal", 32'(terminal), 0);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int r = 0; r < 3000; r++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      load     = ($urandom_range(0, 49) == 0);
      load_val = WIDTH'($urandom_range(0, MAXC));
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) sat = ~sat;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
